// File: rtl/bus_gate_if.sv
// Bus gate arbitration bundle: requests in, one-hot gates and status out.
interface bus_gate_if;
  logic [3:0] req;
  logic       gate_marmux;
  logic       gate_pc;
  logic       gate_alu;
  logic       gate_mdr;
  logic [1:0] bus_owner;
  logic       bus_busy;
  logic       forced_rel;

  modport master (
    output req,
    input  gate_marmux,
    input  gate_pc,
    input  gate_alu,
    input  gate_mdr,
    input  bus_owner,
    input  bus_busy,
    input  forced_rel
  );

  modport slave (
    input  req,
    output gate_marmux,
    output gate_pc,
    output gate_alu,
    output gate_mdr,
    output bus_owner,
    output bus_busy,
    output forced_rel
  );
endinterface

// File: rtl/bus_gate_arbiter.sv
// Round-robin bus gate arbiter with hold limit and turnaround gap.
module bus_gate_arbiter #(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input logic       clk,
  input logic       rst_n,
  bus_gate_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  localparam logic [3:0] TURN_LIM = 4'(TURNAROUND - 1);
  localparam bit         HAS_TURN = (TURNAROUND != 0);

  state_t     state_q, state_d;
  logic [3:0] gates_q, gates_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       forced_q, forced_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] turn_q, turn_d;
  logic [1:0] last_q, last_d;
  logic [2:0] pick;
  logic       arb;
  logic       others;

  // Lowest offset from last winner is applied last, so it wins.
  function automatic logic [2:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] last
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    forced_d = 1'b0;
    hold_d   = hold_q;
    turn_d   = turn_q;
    last_d   = last_q;
    arb      = 1'b0;
    pick     = rr_pick(bus.req, last_q);
    others   = |(bus.req & ~(4'b0001 << owner_q));
    unique case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (!bus.req[owner_q] ||
            (hold_q == HOLD_LIM && others)) begin
          busy_d   = 1'b0;
          forced_d = bus.req[owner_q];
          if (HAS_TURN) begin
            state_d = TURN;
            turn_d  = '0;
          end else begin
            arb = 1'b1;
          end
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q == TURN_LIM) arb = 1'b1;
        else turn_d = turn_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (pick[2]) begin
        state_d = GRANT;
        owner_d = pick[1:0];
        last_d  = pick[1:0];
        busy_d  = 1'b1;
        hold_d  = '0;
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end
    gates_d = busy_d ? (4'b0001 << owner_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gates_q  <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      forced_q <= 1'b0;
      hold_q   <= '0;
      turn_q   <= '0;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      gates_q  <= gates_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      forced_q <= forced_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      last_q   <= last_d;
    end
  end

  assign bus.gate_marmux = gates_q[0];
  assign bus.gate_pc     = gates_q[1];
  assign bus.gate_alu    = gates_q[2];
  assign bus.gate_mdr    = gates_q[3];
  assign bus.bus_owner   = owner_q;
  assign bus.bus_busy    = busy_q;
  assign bus.forced_rel  = forced_q;
endmodule

// File: doc/bus_gate_arbiter.md
BUS_GATE_ARBITER -- requirements
Module: bus_gate_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, max consecutive GRANT cycles before a forced release when other requests are pending (legal range 1..255).
REQ-002 Parameter TURNAROUND, default 1, bus-idle cycles inserted between owners (legal range 0..15).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  bus requests; index 0=MARMUX, 1=PC, 2=ALU, 3=MDR.
REQ-006 gate_marmux  output  1  registered bus gate for MARMUX (owner index 0).
REQ-007 gate_pc  output  1  registered bus gate for PC (owner index 1).
REQ-008 gate_alu  output  1  registered bus gate for ALU (owner index 2).
REQ-009 gate_mdr  output  1  registered bus gate for MDR (owner index 3).
REQ-010 bus_owner  output  2  index of the current owner; valid only while bus_busy=1.
REQ-011 bus_busy  output  1  high exactly when one gate is high.
REQ-012 forced_rel  output  1  one-cycle pulse on the cycle a grant is revoked by the MAX_HOLD limit.

Function
REQ-013 The four gate outputs shall be one-hot or all-zero in every cycle, never more than one high.
REQ-014 The FSM shall have states IDLE, GRANT and TURN.
REQ-015 IDLE: all gates 0; when any req bit is sampled high, the block shall select a winner and enter GRANT, with the winner's gate high in the next cycle (1-cycle latency).
REQ-016 Winner selection shall be round-robin: search indices (last_owner+1) mod 4, (last_owner+2) mod 4, and so on with wrap; the first set req bit wins, and last_owner updates to the winner.
REQ-017 GRANT: the owner's gate stays high; hold_cnt (8-bit) starts at 0 on entry and increments each GRANT cycle, saturating at MAX_HOLD-1.
REQ-018 GRANT voluntary release: req[owner] sampled low -> gates 0 next cycle; next state TURN if TURNAROUND>0, else direct arbitration as in REQ-015.
REQ-019 GRANT forced release: hold_cnt==MAX_HOLD-1 with req[owner] high and any other req bit high -> gates 0 next cycle, forced_rel pulses for that cycle, and the next state follows REQ-018.
REQ-020 At the hold limit with no other requester, the owner shall keep the bus indefinitely and hold_cnt shall stay saturated.
REQ-021 When a voluntary and a forced release occur in the same cycle, the block shall treat it as voluntary (forced_rel stays 0).
REQ-022 TURN: all gates 0 for exactly TURNAROUND cycles; on the last TURN cycle it shall arbitrate per REQ-016 into GRANT, or go to IDLE if req==0.
REQ-023 A sole requester may be re-granted after its own release, but only after passing through TURN.
REQ-024 Req bits that rise and fall entirely within a TURN window shall be ignored, with no queuing.
REQ-025 bus_owner and bus_busy shall be registered alongside the gates and stay consistent with them every cycle.

Reset
REQ-026 Reset low shall asynchronously force state=IDLE, all gates 0, bus_busy=0, bus_owner=0, forced_rel=0, hold_cnt=0 and last_owner=3, so MARMUX has first priority.
REQ-027 Reset asserted mid-GRANT shall drop the gate in the same cycle, without waiting for a clock edge.
REQ-028 After reset deasserts, the first arbitration shall occur on the first rising edge at which req is sampled nonzero.

Verification
REQ-029 Post-reset req=4'b1111 held, defaults -> gate_marmux=1 for 8 cycles, forced_rel pulse, 1 idle cycle, gate_pc=1, then gate_alu, then gate_mdr, then gate_marmux again.
REQ-030 req=4'b0100 for 3 cycles then 0 -> gate_alu high 3 cycles starting 1 cycle after req rises; bus_owner=2; 1 TURN cycle; then IDLE.
REQ-031 req=4'b0010 held 20 cycles alone -> gate_pc high continuously; forced_rel never pulses.
REQ-032 TURNAROUND=0, req[0] drops on the same edge req[3] rises -> gate_marmux 1->0 and gate_mdr 0->1 on the same edge, with no cycle where both are high.
REQ-033 Reset pulsed low mid-GRANT of ALU -> gate_alu drops immediately; after release with req=4'b1100, gate_mdr is not granted first and gate_alu (index 2) wins per last_owner=3.
REQ-034 A random req stream of 10k cycles with an assertion monitor shall show no more than one gate high in any cycle and bus_busy equal to the OR of the gates.
